// File: rtl/clk_divider_bank.sv
// clk_divider_bank
//   Bank of NCH independent clock dividers running from the 50 MHz board clock.
//   Each channel produces a 50%-duty square wave and a one-cycle tick on every
//   rising edge of that wave. A fast mode swaps in short divisors so that
//   simulations finish quickly.
//
// Ports
//   clk_50m   in   1    system clock, every flop on posedge
//   cr        in   1    asynchronous active-high reset
//   en        in   1    count enable; 0 freezes every channel
//   resync    in   1    synchronous restart of all channels, phase aligned
//   sim_fast  in   1    1 selects SIM_HALF_CNT, 0 selects HALF_CNT
//   clk_out   out  NCH  divided square waves (registered)
//   tick      out  NCH  one-cycle strobe in the cycle clk_out[i] rises
//
// Channel i uses bits [i*CNT_W +: CNT_W] of HALF_CNT / SIM_HALF_CNT as its
// terminal count; the output period is 2*(term+1) enabled cycles.
module clk_divider_bank #(
  parameter int                   NCH          = 3,
  parameter int                   CNT_W        = 32,
  parameter logic [NCH*CNT_W-1:0] HALF_CNT     = {32'd24999, 32'd12499999, 32'd24999999},
  parameter logic [NCH*CNT_W-1:0] SIM_HALF_CNT = {32'd24, 32'd124, 32'd249}
) (
  input  logic           clk_50m,
  input  logic           cr,
  input  logic           en,
  input  logic           resync,
  input  logic           sim_fast,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);

  // Reject parameter sets that cannot describe a usable bank.
  if (NCH < 1) begin : g_err_nch
    $error("clk_divider_bank: NCH must be at least 1");
  end
  if (CNT_W < 1) begin : g_err_cnt_w
    $error("clk_divider_bank: CNT_W must be at least 1");
  end

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [CNT_W-1:0] term_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clk_q;
    logic             clk_d;
    logic             tick_q;
    logic             tick_d;

    // Next-state for one channel: resync beats enable, enable advances the count.
    always_comb begin
      term_s = sim_fast ? SIM_HALF_CNT[gi*CNT_W +: CNT_W] : HALF_CNT[gi*CNT_W +: CNT_W];
      cnt_d  = cnt_q;
      clk_d  = clk_q;
      tick_d = 1'b0;
      if (resync) begin
        cnt_d = CNT_ZERO;
        clk_d = 1'b0;
      end else if (en) begin
        // ">=" rather than "==": a switch to a shorter divisor that leaves the
        // count above the new terminal wraps at once instead of running to 2^CNT_W.
        if (cnt_q >= term_s) begin
          cnt_d  = CNT_ZERO;
          clk_d  = ~clk_q;
          tick_d = ~clk_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        cnt_d = cnt_q;
        clk_d = clk_q;
      end
    end

    // Channel state register with asynchronous clear.
    always_ff @(posedge clk_50m or posedge cr) begin
      if (cr) begin
        cnt_q  <= CNT_ZERO;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign clk_out[gi] = clk_q;
    assign tick[gi]    = tick_q;
  end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Self-checking bench for clk_divider_bank with default parameters.
module tb_clk_divider_bank;

  localparam int NCH = 3;
  localparam int SIM_T  [NCH] = '{249, 124, 24};
  localparam int FULL_T [NCH] = '{24999999, 12499999, 24999};

  logic           clk_50m = 1'b0;
  logic           cr;
  logic           en;
  logic           resync;
  logic           sim_fast;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  int checks   = 0;
  int failures = 0;

  // reference model: elapsed enabled cycles since each channel's last toggle
  logic [NCH-1:0] m_out;
  logic [NCH-1:0] m_tick;
  int             m_k [NCH];

  int             cyc = 0;
  int             mark;
  int             pause_lo;
  logic [NCH-1:0] prev;
  int             rises [NCH][$];

  always #10 clk_50m = ~clk_50m;

  clk_divider_bank dut (
    .clk_50m  (clk_50m),
    .cr       (cr),
    .en       (en),
    .resync   (resync),
    .sim_fast (sim_fast),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_out  = '0;
    m_tick = '0;
    for (int c = 0; c < NCH; c++) m_k[c] = 0;
  endtask

  task automatic model_edge();
    int term;
    if (cr || resync) begin
      model_reset();
    end else if (en) begin
      for (int c = 0; c < NCH; c++) begin
        term = sim_fast ? SIM_T[c] : FULL_T[c];
        if (m_k[c] >= term) begin
          m_tick[c] = ~m_out[c];
          m_out[c]  = ~m_out[c];
          m_k[c]    = 0;
        end else begin
          m_k[c]    = m_k[c] + 1;
          m_tick[c] = 1'b0;
        end
      end
    end else begin
      m_tick = '0;
    end
  endtask

  // one clock edge: update model, sample DUT 1 time unit later, log rises
  task automatic step();
    @(posedge clk_50m);
    cyc++;
    model_edge();
    #1;
    check_eq("clk_out", 32'(clk_out), 32'(m_out));
    check_eq("tick", 32'(tick), 32'(m_tick));
    for (int c = 0; c < NCH; c++)
      if (clk_out[c] && !prev[c]) rises[c].push_back(cyc);
    prev = clk_out;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_rises();
    for (int c = 0; c < NCH; c++) rises[c].delete();
  endtask

  // fast mode from a clean start: first rise and number of rises in 2000 cycles
  task automatic scen1();
    int first;
    int per;
    sim_fast = 1'b1;
    en       = 1'b1;
    resync   = 1'b0;
    cr       = 1'b0;
    mark     = cyc;
    clear_rises();
    run(2000);
    for (int c = 0; c < NCH; c++) begin
      first = SIM_T[c] + 1;
      per   = 2 * (SIM_T[c] + 1);
      check_eq($sformatf("s1_nrise_ch%0d", c), 32'(rises[c].size()), 32'((2000 - first) / per + 1));
      check_eq($sformatf("s1_first_ch%0d", c),
               (rises[c].size() > 0) ? 32'(rises[c][0] - mark) : 32'hFFFF_FFFF, 32'(first));
    end
  endtask

  // assert cr between edges, check immediate clear, hold through one edge
  task automatic async_pulse();
    #4;
    cr = 1'b1;
    #1;
    check_eq("async_clk", 32'(clk_out), 32'd0);
    check_eq("async_tick", 32'(tick), 32'd0);
    model_reset();
    prev = '0;
    step();
    cr = 1'b0;
  endtask

  initial begin
    int exp_gap;
    cr       = 1'b1;
    en       = 1'b0;
    resync   = 1'b0;
    sim_fast = 1'b1;
    prev     = '0;
    model_reset();
    #3;
    check_eq("rst_clk", 32'(clk_out), 32'd0);
    check_eq("rst_tick", 32'(tick), 32'd0);
    run(2);

    // 1: free run in fast mode
    scen1();

    // 2: 37-cycle pause mid-count delays every later edge by 37
    en = 1'b1;
    run(100);
    pause_lo = cyc;
    en = 1'b0;
    run(37);
    en = 1'b1;
    run(900);
    for (int c = 0; c < NCH; c++) begin
      for (int j = 0; j + 1 < rises[c].size(); j++) begin
        exp_gap = 2 * (SIM_T[c] + 1);
        if (rises[c][j] <= pause_lo && rises[c][j+1] > pause_lo) exp_gap = exp_gap + 37;
        check_eq($sformatf("s2_period_ch%0d", c), 32'(rises[c][j+1] - rises[c][j]), 32'(exp_gap));
      end
    end

    // 3: resync pulse with en low, then aligned restart
    resync = 1'b1;
    en     = 1'b0;
    step();
    check_eq("s3_clk", 32'(clk_out), 32'd0);
    check_eq("s3_tick", 32'(tick), 32'd0);
    resync = 1'b0;
    en     = 1'b1;
    mark   = cyc;
    clear_rises();
    run(260);
    for (int c = 0; c < NCH; c++)
      check_eq($sformatf("s3_first_ch%0d", c),
               (rises[c].size() > 0) ? 32'(rises[c][0] - mark) : 32'hFFFF_FFFF, 32'(SIM_T[c] + 1));

    // 4: slow divisors for 1000 cycles, then fast: every channel wraps at once
    resync = 1'b1;
    step();
    resync   = 1'b0;
    sim_fast = 1'b0;
    run(1000);
    sim_fast = 1'b1;
    step();
    check_eq("s4_wrap_clk", 32'(clk_out), 32'd7);
    check_eq("s4_wrap_tick", 32'(tick), 32'd7);
    run(1000);

    // 5: async reset while clk_out[0] is high, then clean restart
    for (int i = 0; i < 1000 && !clk_out[0]; i++) step();
    check_eq("s5_ch0_high", 32'(clk_out[0]), 32'd1);
    async_pulse();
    scen1();

    // randomized enable / resync / mode / reset traffic
    for (int i = 0; i < 3000; i++) begin
      en     = ($urandom_range(0, 9) != 0);
      resync = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 299) == 0) sim_fast = ~sim_fast;
      if ($urandom_range(0, 599) == 0) async_pulse();
      step();
    end
    en       = 1'b1;
    resync   = 1'b0;
    sim_fast = 1'b1;
    run(600);

    // 6: full-rate divisors, first rise of the 1 kHz channel
    resync   = 1'b1;
    sim_fast = 1'b0;
    step();
    resync = 1'b0;
    mark   = cyc;
    clear_rises();
    run(FULL_T[2] + 2);
    check_eq("s6_nrise_ch2", 32'(rises[2].size()), 32'd1);
    check_eq("s6_first_ch2",
             (rises[2].size() > 0) ? 32'(rises[2][0] - mark) : 32'hFFFF_FFFF, 32'(FULL_T[2] + 1));
    check_eq("s6_nrise_ch0", 32'(rises[0].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
